// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encodings for the UART receiver
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 3;
    localparam int ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_START   = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA    = 3'd2;
    localparam logic [ST_W-1:0] ST_PARITY  = 3'd3;
    localparam logic [ST_W-1:0] ST_STOP    = 3'd4;
    localparam logic [ST_W-1:0] ST_BREAK   = 3'd5;
    localparam logic [ST_W-1:0] ST_CLEANUP = 3'd6;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an asynchronous single-bit input
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-N-1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Rx_Serial,
    output logic              o_Rx_DV,
    output logic [DATA_W-1:0] o_Rx_Byte,
    output logic              o_Rx_Active,
    output logic              o_Rx_Err
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              rx_s;

    logic [ST_W-1:0]   state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic [DATA_W-1:0] byte_q,   byte_d;
    logic              dv_q,     dv_d;
    logic              err_q,    err_d;
    logic              active_q, active_d;
    logic              frame_ok;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (i_Clock),
        .rst_ni (i_Rst_n),
        .d_i    (i_Rx_Serial),
        .q_o    (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign frame_ok = rx_s && !perr_q;
`else
    assign frame_ok = rx_s;
`endif

    // Next-state logic: mid-bit sampling FSM; DV/Err default low so they pulse for one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
`ifdef UART_RX_PARITY_EN
                perr_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        active_d = 1'b1;
                        state_d  = ST_DATA;
                    end else begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ even_parity(shift_q);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (frame_ok) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = ST_CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        // A low stop bit may be a break: wait for idle so it errors only once.
                        state_d = rx_s ? ST_CLEANUP : ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_CLEANUP;
                end
            end
            ST_CLEANUP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight silently.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity-error flag captured at the parity sample, consumed at the stop sample.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Active = active_q;
    assign o_Rx_Err    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (honours UART_RX_PARITY_EN)
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int EXP_ACTIVE  = (8 + PAR_BITS + 1) * CPB;
    localparam int EXP_LATENCY = 2 + 1 + (CPB - 1) / 2 + 1 + CPB + 7 * CPB + PAR_BITS * CPB + CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       err;

    int n_cmp = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    int active_cycles = 0;
    int cyc = 0;
    int last_dv_cyc = 0;
    int t0 = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Active (active),
        .o_Rx_Err    (err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (active) active_cycles++;
            if (err) err_cnt++;
            if (dv || err) check("dv_err_exclusive", int'(dv && err), 0);
            if (dv) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_dv_byte", int'(rx_byte), -1);
                end else begin
                    check("sb_byte", int'(rx_byte), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip, input int hold);
        t0 = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ pflip, CPB);
`else
        if (pflip) drive_bit(1'b0, 0);
`endif
        drive_bit(stop, CPB);
        if (!stop) drive_bit(1'b0, hold);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         gap;
        int         exp_dv;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0, e0, a0;
        vecs[0] = '{8'hA5, 1'b1, 0, 20, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 0, 1,  1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1,  1, 0};
        vecs[3] = '{8'h81, 1'b1, 0, 20, 1, 0};
        vecs[4] = '{8'h99, 1'b0, 8, 20, 0, 1};
        vecs[5] = '{8'h7E, 1'b1, 0, 20, 1, 0};
        vecs[6] = '{8'h3C, 1'b1, 0, 20, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_dv", int'(dv), 0);
        check("reset_byte", int'(rx_byte), 0);
        check("reset_active", int'(active), 0);
        check("reset_err", int'(err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 10);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            d0 = dv_cnt;
            e0 = err_cnt;
            active_cycles = 0;
            if (vecs[i].exp_dv != 0) begin
                exp_q.push_back(vecs[i].data);
                last_good = vecs[i].data;
            end
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].hold);
            drive_bit(1'b1, vecs[i].gap);
            check($sformatf("vec%0d_dv_count", i), dv_cnt - d0, vecs[i].exp_dv);
            check($sformatf("vec%0d_err_count", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_byte", i), int'(rx_byte), int'(last_good));
            if (i == 0) begin
                check("a5_active_cycles", active_cycles, EXP_ACTIVE);
                check("a5_dv_latency", last_dv_cyc - t0, EXP_LATENCY);
                check("a5_active_low_after", int'(active), 0);
            end
        end

        // Idle-line glitch of 2 cycles
        d0 = dv_cnt; e0 = err_cnt; a0 = active_cycles;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 30);
        check("glitch_dv", dv_cnt - d0, 0);
        check("glitch_err", err_cnt - e0, 0);
        check("glitch_active", active_cycles - a0, 0);

        // Stop bit low then break held low for 40 cycles
        d0 = dv_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 40);
        drive_bit(1'b1, 20);
        check("break_err_count", err_cnt - e0, 1);
        check("break_dv_count", dv_cnt - d0, 0);
        check("break_byte_held", int'(rx_byte), 8'h3C);
        d0 = dv_cnt;
        exp_q.push_back(8'h12);
        last_good = 8'h12;
        send_frame(8'h12, 1'b1, 1'b0, 0);
        drive_bit(1'b1, 20);
        check("after_break_dv", dv_cnt - d0, 1);
        check("after_break_byte", int'(rx_byte), 8'h12);

        // Reset during data bit 4 of 0xC3
        d0 = dv_cnt; e0 = err_cnt;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), CPB);
        drive_bit(1'b0, CPB / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("midreset_byte", int'(rx_byte), 0);
        check("midreset_dv", int'(dv), 0);
        check("midreset_active", int'(active), 0);
        check("midreset_err", int'(err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_good = 8'h00;
        drive_bit(1'b1, 30);
        check("aborted_dv", dv_cnt - d0, 0);
        check("aborted_err", err_cnt - e0, 0);
        exp_q.push_back(8'h5A);
        last_good = 8'h5A;
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        drive_bit(1'b1, 20);
        check("post_reset_dv", dv_cnt - d0, 1);
        check("post_reset_byte", int'(rx_byte), 8'h5A);

`ifdef UART_RX_PARITY_EN
        // Parity: correct bit then flipped bit
        d0 = dv_cnt; e0 = err_cnt;
        exp_q.push_back(8'h37);
        last_good = 8'h37;
        send_frame(8'h37, 1'b1, 1'b0, 0);
        drive_bit(1'b1, 20);
        check("parity_good_dv", dv_cnt - d0, 1);
        check("parity_good_byte", int'(rx_byte), 8'h37);
        d0 = dv_cnt; e0 = err_cnt;
        send_frame(8'h37, 1'b1, 1'b1, 0);
        drive_bit(1'b1, 20);
        check("parity_bad_err", err_cnt - e0, 1);
        check("parity_bad_dv", dv_cnt - d0, 0);
`endif

        check("final_byte", int'(rx_byte), int'(last_good));
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
